// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the flag/branch unit: branch kinds, ARMv8 condition codes,
// NZCV bit positions and the redirect FSM states.
// Imported by the interface, the condition evaluator and the top.
package flag_branch_unit_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // Bit positions inside the {N,Z,C,V} vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } fbu_state_t;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle between the pipeline (master) and the flag/branch unit (slave).
// Master drives stall, EX flag inputs and the ID branch descriptor;
// slave returns redirect_valid/redirect_pc, id_kill and architectural flags.
// Optional macro BRANCH_STATS_EN adds stat_taken/stat_not_taken (STAT_W each).
interface flag_branch_unit_if
    import flag_branch_unit_pkg::*;
#(
    parameter int ADDR_W = 64
`ifdef BRANCH_STATS_EN
    , parameter int STAT_W = 32
`endif
);
    // pipeline -> unit
    logic              stall;
    logic              ex_valid;
    logic              ex_set_flags;
    logic              alu_negative;
    logic              alu_zero;
    logic              alu_overflow;
    logic              alu_carry_out;
    logic              id_valid;
    br_type_t          id_br_type;
    cond_t             id_cond;
    logic              id_rt_zero;
    logic [ADDR_W-1:0] id_target;
    // unit -> pipeline
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_kill;
    logic [3:0]        flags;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_taken;
    logic [STAT_W-1:0] stat_not_taken;
`endif

    modport master (
        output stall, ex_valid, ex_set_flags,
        output alu_negative, alu_zero, alu_overflow, alu_carry_out,
        output id_valid, id_br_type, id_cond, id_rt_zero, id_target,
        input  redirect_valid, redirect_pc, id_kill, flags
`ifdef BRANCH_STATS_EN
        , input stat_taken, stat_not_taken
`endif
    );

    modport slave (
        input  stall, ex_valid, ex_set_flags,
        input  alu_negative, alu_zero, alu_overflow, alu_carry_out,
        input  id_valid, id_br_type, id_cond, id_rt_zero, id_target,
        output redirect_valid, redirect_pc, id_kill, flags
`ifdef BRANCH_STATS_EN
        , output stat_taken, stat_not_taken
`endif
    );

endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Purpose: evaluate an ARMv8 condition code against an {N,Z,C,V} vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state, no handshake.
// Ports: nzcv[3:0] in, cond[3:0] in, pass out.
module cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       pass
);
    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;   // ARMv8 treats NV as always
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Purpose: NZCV register with EX->ID forwarding; resolves B.cond/CBZ/CBNZ in ID.
// Latency: branch in ID at cycle t -> redirect_valid pulse in t+1; ID at t+1 killed.
// Backpressure: stall freezes flags, FSM and redirect outputs (pulse stretches).
// Ports: clk, reset (sync, active-low), bus (flag_branch_unit_if.slave).
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken counters.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int ADDR_W = 64
`ifdef BRANCH_STATS_EN
    , parameter int STAT_W = 32
`endif
)(
    input  logic              clk,
    input  logic              reset,
    flag_branch_unit_if.slave bus
);
    logic [3:0]        flags_q, flags_d;
    fbu_state_t        state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic       ex_writes_flags;
    logic [3:0] alu_nzcv;
    logic [3:0] eff_flags;
    logic       cond_pass;
    logic       br_hit;
    logic       id_kill;
    logic       take;

    assign ex_writes_flags = bus.ex_valid && bus.ex_set_flags;
    assign alu_nzcv = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};

    // A flag-setter in EX is older than the branch in ID, so its live flags win.
    assign eff_flags = ex_writes_flags ? alu_nzcv : flags_q;

    cond_eval u_cond_eval (
        .nzcv (eff_flags),
        .cond (bus.id_cond),
        .pass (cond_pass)
    );

    // The instruction in ID while a redirect is out was fetched down the wrong path.
    assign id_kill = (state_q == REDIRECT);

    always_comb begin
        br_hit = 1'b0;
        case (bus.id_br_type)
            BR_COND: br_hit = cond_pass;
            BR_CBZ:  br_hit = bus.id_rt_zero;
            BR_CBNZ: br_hit = !bus.id_rt_zero;
            default: br_hit = 1'b0;
        endcase
    end

    assign take = bus.id_valid && !id_kill && br_hit;

    always_comb begin
        flags_d          = flags_q;
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (!bus.stall) begin
            if (ex_writes_flags) begin
                flags_d = alu_nzcv;
            end
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_d          = REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = bus.id_target;
                    end else begin
                        redirect_valid_d = 1'b0;
                    end
                end
                REDIRECT: begin
                    state_d          = IDLE;
                    redirect_valid_d = 1'b0;
                end
                default: begin
                    state_d          = IDLE;
                    redirect_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q          <= 4'b0000;
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            flags_q          <= flags_d;
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.flags          = flags_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.id_kill        = id_kill;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_taken_q, stat_taken_d;
    logic [STAT_W-1:0] stat_not_taken_q, stat_not_taken_d;
    logic              resolved;

    // A branch counts once, when it actually leaves ID on a live path.
    assign resolved = bus.id_valid && !id_kill && !bus.stall && (bus.id_br_type != BR_NONE);

    always_comb begin
        stat_taken_d     = stat_taken_q;
        stat_not_taken_d = stat_not_taken_q;
        if (resolved) begin
            if (take) begin
                if (stat_taken_q != {STAT_W{1'b1}}) stat_taken_d = stat_taken_q + 1'b1;
            end else begin
                if (stat_not_taken_q != {STAT_W{1'b1}}) stat_not_taken_d = stat_not_taken_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
        end else begin
            stat_taken_q     <= stat_taken_d;
            stat_not_taken_q <= stat_not_taken_d;
        end
    end

    assign bus.stat_taken     = stat_taken_q;
    assign bus.stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: reset, forwarding, condition table,
// back-to-back kill, stall stretch, reset mid-redirect, optional statistics.
module tb_flag_branch_unit;
    import flag_branch_unit_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

`ifdef BRANCH_STATS_EN
    flag_branch_unit_if #(.ADDR_W(64), .STAT_W(4)) bus ();
    flag_branch_unit #(.ADDR_W(64), .STAT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    flag_branch_unit_if #(.ADDR_W(64)) bus ();
    flag_branch_unit #(.ADDR_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_set_flags  = 1'b0;
        bus.alu_negative  = 1'b0;
        bus.alu_zero      = 1'b0;
        bus.alu_overflow  = 1'b0;
        bus.alu_carry_out = 1'b0;
        bus.id_valid      = 1'b0;
        bus.id_br_type    = BR_NONE;
        bus.id_cond       = COND_EQ;
        bus.id_rt_zero    = 1'b0;
        bus.id_target     = '0;
    endtask

    // Present an EX flag-setter with the given {N,Z,C,V}.
    task automatic drive_ex(input logic [3:0] nzcv);
        bus.ex_valid      = 1'b1;
        bus.ex_set_flags  = 1'b1;
        bus.alu_negative  = nzcv[3];
        bus.alu_zero      = nzcv[2];
        bus.alu_carry_out = nzcv[1];
        bus.alu_overflow  = nzcv[0];
    endtask

    task automatic drive_br(input br_type_t t, input cond_t c, input logic rtz, input logic [63:0] tgt);
        bus.id_valid   = 1'b1;
        bus.id_br_type = t;
        bus.id_cond    = c;
        bus.id_rt_zero = rtz;
        bus.id_target  = tgt;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.id_kill !== 1'b0) begin errors++; $display("FAIL reset_kill got=%b exp=0", bus.id_kill); end
        checks++; if (bus.redirect_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.redirect_pc); end
        reset = 1'b1;
    endtask

    task automatic test_forward_beq();
        clear_inputs();
        drive_ex(4'b0110);
        drive_br(BR_COND, COND_EQ, 1'b0, 64'h100);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL fwd_rv got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 64'h100) begin errors++; $display("FAIL fwd_pc got=%h exp=100", bus.redirect_pc); end
        checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL fwd_flags got=%b exp=0110", bus.flags); end
        checks++; if (bus.id_kill !== 1'b1) begin errors++; $display("FAIL fwd_kill got=%b exp=1", bus.id_kill); end
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL fwd_pulse_end got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 64'h100) begin errors++; $display("FAIL fwd_pc_hold got=%h exp=100", bus.redirect_pc); end
    endtask

    task automatic test_arch_flags();
        clear_inputs();
        drive_ex(4'b1000);
        step();
        clear_inputs();
        checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL arch_flags got=%b exp=1000", bus.flags); end
        // Non-valid EX must neither forward nor update: Z=1 here must not make B.EQ pass.
        bus.ex_valid = 1'b0; bus.ex_set_flags = 1'b1; bus.alu_zero = 1'b1;
        drive_br(BR_COND, COND_EQ, 1'b0, 64'h180);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL exinv_rv got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL exinv_flags got=%b exp=1000", bus.flags); end
        drive_br(BR_COND, COND_GE, 1'b0, 64'h1C0);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL bge_rv got=%b exp=0", bus.redirect_valid); end
        drive_br(BR_COND, COND_LT, 1'b0, 64'h200);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL blt_rv got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.id_kill !== 1'b1) begin errors++; $display("FAIL blt_kill got=%b exp=1", bus.id_kill); end
        checks++; if (bus.redirect_pc !== 64'h200) begin errors++; $display("FAIL blt_pc got=%h exp=200", bus.redirect_pc); end
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL blt_end got=%b exp=0", bus.redirect_valid); end
    endtask

    // exp[c] is the hand-derived pass bit for condition c under nzcv.
    task automatic test_cond_table(input logic [3:0] nzcv, input logic [15:0] exp, input bit fwd);
        clear_inputs();
        if (!fwd) begin
            drive_ex(nzcv);
            step();
            clear_inputs();
        end
        for (int c = 0; c < 16; c++) begin
            if (fwd) drive_ex(nzcv);
            drive_br(BR_COND, cond_t'(c), 1'b0, 64'h1000 + 64'(c));
            step();
            clear_inputs();
            checks++;
            if (bus.redirect_valid !== exp[c]) begin
                errors++;
                $display("FAIL cond nzcv=%b cond=%0d got=%b exp=%b", nzcv, c, bus.redirect_valid, exp[c]);
            end
            if (exp[c]) begin
                checks++;
                if (bus.redirect_pc !== 64'h1000 + 64'(c)) begin
                    errors++;
                    $display("FAIL cond_pc cond=%0d got=%h exp=%h", c, bus.redirect_pc, 64'h1000 + 64'(c));
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        drive_br(BR_CBZ, COND_EQ, 1'b1, 64'h40);
        step();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv1 got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 64'h40) begin errors++; $display("FAIL b2b_pc1 got=%h exp=40", bus.redirect_pc); end
        checks++; if (bus.id_kill !== 1'b1) begin errors++; $display("FAIL b2b_kill got=%b exp=1", bus.id_kill); end
        drive_br(BR_CBNZ, COND_EQ, 1'b0, 64'h80);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL b2b_rv2 got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 64'h40) begin errors++; $display("FAIL b2b_pc2 got=%h exp=40", bus.redirect_pc); end
        checks++; if (bus.id_kill !== 1'b0) begin errors++; $display("FAIL b2b_kill2 got=%b exp=0", bus.id_kill); end
        // Not-taken forms of the compare-and-branch instructions.
        drive_br(BR_CBZ, COND_EQ, 1'b0, 64'h44);
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL cbz_nt got=%b exp=0", bus.redirect_valid); end
        drive_br(BR_CBNZ, COND_EQ, 1'b1, 64'h88);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL cbnz_nt got=%b exp=0", bus.redirect_valid); end
    endtask

    task automatic test_stall();
        clear_inputs();
        drive_ex(4'b0001);
        step();
        clear_inputs();
        drive_br(BR_CBNZ, COND_EQ, 1'b0, 64'h300);
        step();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL stall_rv0 got=%b exp=1", bus.redirect_valid); end
        // While frozen, new flag writes and a fresh branch must all be ignored.
        bus.stall = 1'b1;
        drive_ex(4'b1111);
        drive_br(BR_CBZ, COND_EQ, 1'b1, 64'h999);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL stall_rv cyc=%0d got=%b exp=1", i, bus.redirect_valid); end
            checks++; if (bus.redirect_pc !== 64'h300) begin errors++; $display("FAIL stall_pc cyc=%0d got=%h exp=300", i, bus.redirect_pc); end
            checks++; if (bus.flags !== 4'b0001) begin errors++; $display("FAIL stall_flags cyc=%0d got=%b exp=0001", i, bus.flags); end
        end
        clear_inputs();
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flags !== 4'b0001) begin errors++; $display("FAIL stall_flags_after got=%b exp=0001", bus.flags); end
    endtask

    task automatic test_reset_mid_redirect();
        clear_inputs();
        drive_ex(4'b1010);
        drive_br(BR_COND, COND_AL, 1'b0, 64'h500);
        step();
        clear_inputs();
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL rmid_rv got=%b exp=1", bus.redirect_valid); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rmid_rv_after got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.id_kill !== 1'b0) begin errors++; $display("FAIL rmid_kill got=%b exp=0", bus.id_kill); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rmid_flags got=%b exp=0000", bus.flags); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        test_reset();
        for (int i = 0; i < 20; i++) begin
            drive_br(BR_CBZ, COND_EQ, 1'b1, 64'h600);
            step();
            clear_inputs();
            step();
        end
        checks++; if (bus.stat_taken !== 4'd15) begin errors++; $display("FAIL stat_taken got=%0d exp=15", bus.stat_taken); end
        checks++; if (bus.stat_not_taken !== 4'd0) begin errors++; $display("FAIL stat_nt got=%0d exp=0", bus.stat_not_taken); end
        for (int i = 0; i < 3; i++) begin
            drive_br(BR_CBZ, COND_EQ, 1'b0, 64'h700);
            step();
        end
        clear_inputs();
        checks++; if (bus.stat_not_taken !== 4'd3) begin errors++; $display("FAIL stat_nt3 got=%0d exp=3", bus.stat_not_taken); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_forward_beq();
        test_arch_flags();
        test_cond_table(4'b1000, 16'hEA9A, 1'b0);
        test_cond_table(4'b0110, 16'hE6A5, 1'b1);
        test_cond_table(4'b0011, 16'hE966, 1'b0);
        test_back_to_back();
        test_stall();
        test_reset_mid_redirect();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
